// File: rtl/keyed_lock_seq.sv
// keyed_lock_seq: logic-locked sequential core.
// A serially loaded key is compared against a hardwired secret. Until the
// correct key has been accepted, a free-running 16-bit LFSR is XORed into the
// next-state logic of the N_LOCK-bit core register. Wrong keys are counted and
// MAX_TRIES of them drive the controller into an absorbing LOCKOUT state that
// only a reset can leave.
//
// Key interface: KEY_VALID qualifies KEY_IN for exactly one bit per cycle in
// which it is high; there is no back-pressure, so a bit presented while the
// controller is not in LOAD is dropped. KEY_START is a single-cycle request to
// (re)start a key load and wins over KEY_VALID when both are high together.
module keyed_lock_seq #(
    parameter int                KEY_W     = 8,
    parameter logic [KEY_W-1:0]  KEY_VAL   = 8'hA5,
    parameter int                N_LOCK    = 4,
    parameter int                MAX_TRIES = 3,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              KEY_START,
    input  logic              KEY_VALID,
    input  logic              KEY_IN,
    input  logic [N_LOCK-1:0] G_IN,
    output logic [N_LOCK-1:0] Y,
    output logic              UNLOCKED,
    output logic              LOCKOUT,
    output logic              BUSY,
    output logic [3:0]        FAIL_CNT,
    output logic [2:0]        DBG_STATE
);

    // Bit counter must be able to hold KEY_W itself.
    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
    localparam logic [3:0]       TRY_LIMIT = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [KEY_W-1:0]    sreg_q, sreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          fail_q, fail_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [N_LOCK-1:0]   y_q, y_d;
    logic                unlocked_q, lockout_q, busy_q;
    logic [3:0]          fail_inc;

    assign fail_inc = fail_q + 4'd1;

    // Controller next-state: key loading, comparison and retry accounting.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (KEY_START) begin
                    state_d = S_LOAD;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (KEY_START) begin
                    // Restart discards whatever was shifted in so far.
                    sreg_d = '0;
                    cnt_d  = '0;
                end else if (KEY_VALID) begin
                    sreg_d = {sreg_q[KEY_W-2:0], KEY_IN};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (sreg_q == KEY_VAL) begin
                    state_d = S_UNLOCKED;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == TRY_LIMIT) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_UNLOCKED: begin
                if (KEY_START) begin
                    state_d = S_LOAD;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LOCKOUT: begin
                state_d = S_LOCKOUT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller registers; status flags are registered decodes of the next state.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q    <= S_IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            unlocked_q <= (state_d == S_UNLOCKED);
            lockout_q  <= (state_d == S_LOCKOUT);
            busy_q     <= (state_d == S_LOAD) || (state_d == S_CHECK);
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // LFSR register, held at the seed while in reset and free-running after.
    always_ff @(posedge CK) begin
        if (!RN) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Core next-state: rotate-and-XOR, corrupted by the LFSR unless the
    // current state is UNLOCKED (so the first clean update follows UNLOCKED).
    always_comb begin
        y_d = '0;
        for (int i = 0; i < N_LOCK; i++) begin
            y_d[i] = G_IN[i] ^ y_q[(i + 1) % N_LOCK]
                     ^ ((state_q == S_UNLOCKED) ? 1'b0 : lfsr_q[i]);
        end
    end

    // Core state register.
    always_ff @(posedge CK) begin
        if (!RN) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y         = y_q;
    assign UNLOCKED  = unlocked_q;
    assign LOCKOUT   = lockout_q;
    assign BUSY      = busy_q;
    assign FAIL_CNT  = fail_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_keyed_lock_seq.sv
// Testbench for keyed_lock_seq with default parameters (KEY_W=8, KEY_VAL=8'hA5,
// N_LOCK=4, MAX_TRIES=3, LFSR_SEED=16'hACE1).
module tb_keyed_lock_seq;

    logic       CK;
    logic       RN;
    logic       KEY_START;
    logic       KEY_VALID;
    logic       KEY_IN;
    logic [3:0] G_IN;
    logic [3:0] Y;
    logic       UNLOCKED;
    logic       LOCKOUT;
    logic       BUSY;
    logic [3:0] FAIL_CNT;
    logic [2:0] DBG_STATE;

    int n_checks = 0;
    int n_errors = 0;

    // Reference for the core register: clean/corrupted update from the text
    // description; m_unl is set by the test when UNLOCKED is expected high.
    logic [3:0]  m_y;
    logic [15:0] m_lfsr;
    logic        m_unl = 1'b0;

    keyed_lock_seq dut (
        .CK        (CK),
        .RN        (RN),
        .KEY_START (KEY_START),
        .KEY_VALID (KEY_VALID),
        .KEY_IN    (KEY_IN),
        .G_IN      (G_IN),
        .Y         (Y),
        .UNLOCKED  (UNLOCKED),
        .LOCKOUT   (LOCKOUT),
        .BUSY      (BUSY),
        .FAIL_CNT  (FAIL_CNT),
        .DBG_STATE (DBG_STATE)
    );

    // Clock
    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Core reference model
    always @(posedge CK) begin
        if (!RN) begin
            m_y    <= 4'd0;
            m_lfsr <= 16'hACE1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_y[i] <= G_IN[i] ^ m_y[(i + 1) % 4] ^ (m_unl ? 1'b0 : m_lfsr[i]);
            end
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start(input logic exp_busy);
        KEY_START = 1'b1;
        step();
        KEY_START = 1'b0;
        chk("start_busy", BUSY, exp_busy);
    endtask

    task automatic send_bits(input logic [7:0] k, input logic exp_busy);
        for (int b = 7; b >= 0; b--) begin
            KEY_VALID = 1'b1;
            KEY_IN    = k[b];
            step();
            chk($sformatf("bit%0d_busy", b), BUSY, exp_busy);
        end
        KEY_VALID = 1'b0;
        KEY_IN    = 1'b0;
    endtask

    task automatic do_reset();
        RN = 1'b0;
        m_unl = 1'b0;
        step();
        RN = 1'b1;
    endtask

    typedef struct {
        logic       start;
        logic       valid;
        logic       kbit;
        logic       exp_busy;
        logic       exp_unl;
        logic       exp_lock;
        logic [3:0] exp_fail;
    } vec_t;

    vec_t tbl[11];

    typedef struct {
        logic [3:0] g;
        logic [3:0] exp_y;
    } core_vec_t;

    core_vec_t ctbl[5];

    initial begin
        logic [7:0] good;
        int         seen_diff;

        good = 8'hA5;
        RN = 1'b0; KEY_START = 1'b0; KEY_VALID = 1'b0; KEY_IN = 1'b0; G_IN = 4'd0;

        // Unlock sequence: start, 8 bits of 10100101, CHECK, then UNLOCKED.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        for (int k = 0; k < 8; k++) begin
            tbl[k + 1] = '{1'b0, 1'b1, good[7 - k], 1'b1, 1'b0, 1'b0, 4'd0};
        end
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};

        // Clean core rotation after a single G_IN pulse.
        ctbl[0] = '{4'b0001, 4'b0001};
        ctbl[1] = '{4'b0000, 4'b1000};
        ctbl[2] = '{4'b0000, 4'b0100};
        ctbl[3] = '{4'b0000, 4'b0010};
        ctbl[4] = '{4'b0000, 4'b0001};

        // T1 reset
        step();
        step();
        chk("rst_y", Y, 4'd0);
        chk("rst_fail", FAIL_CNT, 4'd0);
        chk("rst_unl", UNLOCKED, 1'b0);
        chk("rst_lock", LOCKOUT, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_state", DBG_STATE, 3'd0);
        RN = 1'b1;
        // First edge uses seed ACE1 (low nibble 0001); second uses 59C3 (0011):
        // 0001 rotated -> 1000, XOR 0011 -> 1011.
        step();
        chk("lfsr_seed_y", Y, 4'b0001);
        step();
        chk("lfsr_next_y", Y, 4'b1011);

        // T2 unlock via table
        for (int i = 0; i < 11; i++) begin
            KEY_START = tbl[i].start;
            KEY_VALID = tbl[i].valid;
            KEY_IN    = tbl[i].kbit;
            step();
            chk($sformatf("t2_row%0d_busy", i), BUSY, tbl[i].exp_busy);
            chk($sformatf("t2_row%0d_unl", i), UNLOCKED, tbl[i].exp_unl);
            chk($sformatf("t2_row%0d_lock", i), LOCKOUT, tbl[i].exp_lock);
            chk($sformatf("t2_row%0d_fail", i), FAIL_CNT, tbl[i].exp_fail);
            chk($sformatf("t2_row%0d_y", i), Y, m_y);
            m_unl = tbl[i].exp_unl;
        end
        KEY_START = 1'b0; KEY_VALID = 1'b0; KEY_IN = 1'b0;

        // T3 clean core: cancel current value to reach Y=0, then pulse G_IN.
        G_IN = {m_y[0], m_y[3:1]};
        step();
        chk("t3_zero", Y, 4'd0);
        for (int i = 0; i < 5; i++) begin
            G_IN = ctbl[i].g;
            step();
            chk($sformatf("t3_rot%0d", i), Y, ctbl[i].exp_y);
        end
        G_IN = 4'd0;

        // T5 relock, partial load, restart (with coincident KEY_VALID), full key.
        KEY_START = 1'b1;
        step();
        KEY_START = 1'b0;
        chk("t5_relock_unl", UNLOCKED, 1'b0);
        chk("t5_relock_busy", BUSY, 1'b1);
        m_unl = 1'b0;
        for (int b = 0; b < 5; b++) begin
            KEY_VALID = 1'b1;
            KEY_IN    = b[0];
            step();
        end
        chk("t5_partial_busy", BUSY, 1'b1);
        KEY_START = 1'b1; KEY_VALID = 1'b1; KEY_IN = 1'b1;
        step();
        KEY_START = 1'b0;
        chk("t5_restart_busy", BUSY, 1'b1);
        send_bits(good, 1'b1);
        step();
        chk("t5_unl", UNLOCKED, 1'b1);
        chk("t5_fail", FAIL_CNT, 4'd0);
        m_unl = 1'b1;
        G_IN = 4'b0110;
        step();
        step();
        chk("t5_core_y", Y, m_y);
        G_IN = 4'd0;

        // T6 corruption from reset with G_IN=0
        do_reset();
        chk("t6_rst_y", Y, 4'd0);
        seen_diff = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("t6_model_c%0d", c), Y, m_y);
            if (c < 4 && Y != 4'd0) seen_diff++;
        end
        chk("t6_differs_clean", (seen_diff > 0), 1'b1);
        // Reset during LOAD discards the partial key.
        pulse_start(1'b1);
        KEY_VALID = 1'b1; KEY_IN = 1'b1;
        step(); step(); step();
        KEY_VALID = 1'b0;
        RN = 1'b0;
        step();
        chk("t6_midrst_state", DBG_STATE, 3'd0);
        chk("t6_midrst_busy", BUSY, 1'b0);
        RN = 1'b1;
        pulse_start(1'b1);
        send_bits(good, 1'b1);
        step();
        chk("t6_after_rst_unl", UNLOCKED, 1'b1);

        // T4 lockout after three wrong keys
        do_reset();
        for (int t = 1; t <= 3; t++) begin
            pulse_start(1'b1);
            send_bits(8'h00, 1'b1);
            step();
            chk($sformatf("t4_try%0d_fail", t), FAIL_CNT, 4'(t));
            chk($sformatf("t4_try%0d_lock", t), LOCKOUT, (t == 3));
            chk($sformatf("t4_try%0d_unl", t), UNLOCKED, 1'b0);
            chk($sformatf("t4_try%0d_busy", t), BUSY, 1'b0);
        end
        pulse_start(1'b0);
        send_bits(good, 1'b0);
        step();
        chk("t4_locked_unl", UNLOCKED, 1'b0);
        chk("t4_locked_lock", LOCKOUT, 1'b1);
        chk("t4_locked_fail", FAIL_CNT, 4'd3);
        chk("t4_locked_y", Y, m_y);
        do_reset();
        chk("t4_rst_lock", LOCKOUT, 1'b0);
        chk("t4_rst_fail", FAIL_CNT, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
